// File: rtl/hex_display_ctrl_pkg.sv
// Shared segment constants and per-digit register layout for the hex display block.
// Segment encodings are active-low, bit 6 = g ... bit 0 = a.
package hex_display_ctrl_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ERR   = 7'b1001001;

  typedef struct packed {
    logic [3:0] value;
    logic       hex;
    logic       blink;
    logic       en;
  } digit_state_t;

endpackage

// File: rtl/hex_display_ctrl_enc7led.sv
// enc7led: nibble to active-low seven-segment glyph; purely combinational.
// Latency: 0 cycles; no handshake, so no backpressure.
module enc7led
  import hex_display_ctrl_pkg::*;
(
  input  logic [3:0] value,
  input  logic       hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_ERR;
    if (value >= 4'd10 && !hex) begin
      seg = SEG_ERR;
    end else begin
      case (value)
        4'd0:    seg = 7'b1000000;
        4'd1:    seg = 7'b1111001;
        4'd2:    seg = 7'b0100100;
        4'd3:    seg = 7'b0110000;
        4'd4:    seg = 7'b0011001;
        4'd5:    seg = 7'b0010010;
        4'd6:    seg = 7'b0000010;
        4'd7:    seg = 7'b1011000;
        4'd8:    seg = 7'b0000000;
        4'd9:    seg = 7'b0010000;
        4'd10:   seg = 7'b0001000;
        4'd11:   seg = 7'b0000011;
        4'd12:   seg = 7'b1000110;
        4'd13:   seg = 7'b0100001;
        4'd14:   seg = 7'b0000110;
        4'd15:   seg = 7'b0001110;
        default: seg = SEG_ERR;
      endcase
    end
  end

endmodule

// File: rtl/hex_display_ctrl.sv
// Round-robin two-port digit writer with a scanned, shared encoder driving registered HEX pins.
// Latency: write to pin <= NUM_DIGITS+1 cycles; ready is combinational and never stalls a lone requester.
module hex_display_ctrl
  import hex_display_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [2:0]              a_digit,
  input  logic [3:0]              a_value,
  input  logic                    a_hex,
  input  logic                    a_blink,
  input  logic                    b_valid,
  output logic                    b_ready,
  input  logic [2:0]              b_digit,
  input  logic [3:0]              b_value,
  input  logic                    b_hex,
  input  logic                    b_blink,
  output logic [7*NUM_DIGITS-1:0] hex_out,
  output logic                    err
);

  localparam int              CW       = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [3:0]      ND       = 4'(NUM_DIGITS);
  localparam logic [2:0]      PTR_LAST = 3'(NUM_DIGITS - 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(BLINK_DIV - 1);

  digit_state_t  dig [NUM_DIGITS];
  logic          prio_b;
  logic [2:0]    ptr;
  logic [CW-1:0] cnt;
  logic          phase;

  logic          a_fire, b_fire, wr_fire, wr_ok;
  logic [2:0]    wr_digit;
  digit_state_t  wr_dat;
  digit_state_t  cur;
  logic [6:0]    enc_seg, scan_seg;

  // Grants are a function of both valids and priority only; rst masks them so nothing lands during reset.
  assign a_ready = !rst && a_valid && (!b_valid || !prio_b);
  assign b_ready = !rst && b_valid && (!a_valid || prio_b);
  assign a_fire  = a_valid && a_ready;
  assign b_fire  = b_valid && b_ready;
  assign wr_fire = a_fire || b_fire;

  always_comb begin
    wr_digit     = a_digit;
    wr_dat.value = a_value;
    wr_dat.hex   = a_hex;
    wr_dat.blink = a_blink;
    wr_dat.en    = 1'b1;
    if (b_fire) begin
      wr_digit     = b_digit;
      wr_dat.value = b_value;
      wr_dat.hex   = b_hex;
      wr_dat.blink = b_blink;
    end
    wr_ok = ({1'b0, wr_digit} < ND);
  end

  always_comb begin
    cur = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (ptr == 3'(k)) cur = dig[k];
    end
  end

  enc7led u_enc (
    .value (cur.value),
    .hex   (cur.hex),
    .seg   (enc_seg)
  );

  assign scan_seg = (!cur.en || (cur.blink && phase)) ? SEG_BLANK : enc_seg;

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_b  <= 1'b0;
      ptr     <= '0;
      cnt     <= '0;
      phase   <= 1'b0;
      err     <= 1'b0;
      hex_out <= {NUM_DIGITS{SEG_BLANK}};
      for (int k = 0; k < NUM_DIGITS; k++) dig[k] <= '0;
    end else begin
      if (a_valid && b_valid) prio_b <= !prio_b;
      ptr <= (ptr == PTR_LAST) ? 3'd0 : ptr + 3'd1;
      if (cnt == CNT_LAST) begin
        cnt   <= '0;
        phase <= !phase;
      end else begin
        cnt <= cnt + CW'(1);
      end
      if (wr_fire && !wr_ok) err <= 1'b1;
      // The scan below reads dig[] before this update, so a same-cycle write shows one pass later.
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (wr_fire && wr_ok && wr_digit == 3'(k)) dig[k] <= wr_dat;
        if (ptr == 3'(k)) hex_out[7*k +: 7] <= scan_seg;
      end
    end
  end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Randomized scoreboard bench for hex_display_ctrl with directed reset, contention, error and blink checks.
module tb_hex_display_ctrl;
  import hex_display_ctrl_pkg::*;

  localparam int N  = 6;
  localparam int BD = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             a_valid, a_ready, a_hex, a_blink;
  logic [2:0]       a_digit;
  logic [3:0]       a_value;
  logic             b_valid, b_ready, b_hex, b_blink;
  logic [2:0]       b_digit;
  logic [3:0]       b_value;
  logic [7*N-1:0]   hex_out;
  logic             err;

  always #5 clk = ~clk;

  hex_display_ctrl #(.NUM_DIGITS(N), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_digit(a_digit), .a_value(a_value), .a_hex(a_hex), .a_blink(a_blink),
    .b_valid(b_valid), .b_ready(b_ready), .b_digit(b_digit), .b_value(b_value), .b_hex(b_hex), .b_blink(b_blink),
    .hex_out(hex_out), .err(err)
  );

  typedef struct { logic v; logic [2:0] d; logic [3:0] val; logic h; logic bl; } req_t;
  typedef struct { int due; bit is_err; int d; logic [6:0] seg; bit bl; } exp_t;

  exp_t       sb [$];
  int         total = 0, bad = 0, cyc = 0, r_cyc = 0;
  bit         prio_m = 0;
  int         last_acc [N];
  logic [3:0] vals [9] = '{4'd0, 4'd3, 4'd7, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, expv, cyc);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] v, input logic h);
    if (v >= 4'd10 && !h) return 7'b1001001;
    case (v)
      4'd0:    return 7'b1000000;
      4'd3:    return 7'b0110000;
      4'd7:    return 7'b1011000;
      4'd10:   return 7'b0001000;
      4'd11:   return 7'b0000011;
      4'd12:   return 7'b1000110;
      4'd13:   return 7'b0100001;
      4'd14:   return 7'b0000110;
      4'd15:   return 7'b0001110;
      default: return 7'bxxxxxxx;
    endcase
  endfunction

  // Cycle c shows what digit d looked like when it was last visited; digit (s-r) mod N is visited in cycle s.
  function automatic logic [6:0] exp_slice(input int d, input int c, input int w, input logic [6:0] g, input bit bl);
    int k, s;
    k = c - 1 - r_cyc;
    if (k < 0) return SEG_BLANK;
    s = c - 1 - (((k - d) % N + N) % N);
    if (s < r_cyc || s <= w) return SEG_BLANK;
    if (bl && (((s - r_cyc) / BD) % 2 == 1)) return SEG_BLANK;
    return g;
  endfunction

  task automatic accept(input req_t r);
    exp_t e;
    e.due = cyc + N + 1;
    if (r.d < N) begin
      e.is_err = 0; e.d = r.d; e.seg = glyph(r.val, r.h); e.bl = r.bl;
      last_acc[r.d] = cyc;
    end else begin
      e.is_err = 1; e.d = 0; e.seg = '0; e.bl = 0;
    end
    sb.push_back(e);
  endtask

  task automatic drive_cycle(input req_t ra, input req_t rb, output bit ga, output bit gb);
    bit ea, eb;
    a_valid = ra.v; a_digit = ra.d; a_value = ra.val; a_hex = ra.h; a_blink = ra.bl;
    b_valid = rb.v; b_digit = rb.d; b_value = rb.val; b_hex = rb.h; b_blink = rb.bl;
    @(negedge clk);
    ea = ra.v && !rst && (!rb.v || !prio_m);
    eb = rb.v && !rst && (!ra.v || prio_m);
    chk("a_ready", a_ready, ea);
    chk("b_ready", b_ready, eb);
    if (rst) prio_m = 0;
    else if (ra.v && rb.v) prio_m = !prio_m;
    ga = a_valid && a_ready;
    gb = b_valid && b_ready;
    if (ga) accept(ra);
    if (gb) accept(rb);
    @(posedge clk); #1;
    a_valid = 0; b_valid = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 40) begin @(posedge clk); #3; n++; end
    chk("drain", sb.size(), 0);
  endtask

  task automatic do_reset();
    a_valid = 0; b_valid = 0; rst = 1;
    repeat (2) @(posedge clk);
    #1;
    sb.delete();
    prio_m = 0;
    rst = 0;
    r_cyc = cyc;
  endtask

  task automatic new_req(output req_t r, input req_t other);
    int d;
    d = $urandom_range(N - 1, 0);
    r.v = 0; r.d = 3'(d); r.val = vals[$urandom_range(8, 0)]; r.h = 1'($urandom_range(1, 0)); r.bl = 0;
    if ((other.v && other.d == 3'(d)) || cyc < last_acc[d] + N + 2) return;
    r.v = 1;
  endtask

  function automatic req_t mk(input logic v, input int d, input int val, input logic h, input logic bl);
    req_t r;
    r.v = v; r.d = 3'(d); r.val = 4'(val); r.h = h; r.bl = bl;
    return r;
  endfunction

  // Scoreboard monitor: each accepted write must be on the pins by its deadline.
  initial begin
    exp_t e;
    logic [6:0] sl;
    forever begin
      @(posedge clk); #2;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        if (e.is_err) begin
          chk("err_sticky", err, 1'b1);
        end else begin
          sl = hex_out[e.d*7 +: 7];
          if (e.bl) begin
            total++;
            if (sl !== e.seg && sl !== SEG_BLANK) begin
              bad++;
              $display("FAIL blink_slice%0d: got %b expected %b or blank", e.d, sl, e.seg);
            end
          end else begin
            chk($sformatf("slice%0d", e.d), sl, e.seg);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    req_t ra, rb, none;
    bit ga, gb;
    int w0, w1;
    logic [7*N-1:0] snap;

    for (int i = 0; i < N; i++) last_acc[i] = -100;
    none = mk(0, 0, 0, 0, 0);
    a_valid = 0; a_digit = 0; a_value = 0; a_hex = 0; a_blink = 0;
    b_valid = 0; b_digit = 0; b_value = 0; b_hex = 0; b_blink = 0;

    do_reset();
    idle(10);
    chk("rst_hex_out", hex_out, {N{SEG_BLANK}});
    chk("rst_err", err, 1'b0);
    chk("rst_a_ready", a_ready, 1'b0);
    chk("rst_b_ready", b_ready, 1'b0);

    drive_cycle(mk(1, 0, 3, 0, 0), none, ga, gb);
    drive_cycle(none, mk(1, 2, 10, 1, 0), ga, gb);
    idle(N + 2);
    drive_cycle(none, mk(1, 2, 10, 0, 0), ga, gb);
    drain();

    // Held contention: A, B, A, then B alone.
    drive_cycle(mk(1, 3, 0, 0, 0), mk(1, 4, 11, 1, 0), ga, gb);
    chk("alt1_a", ga, 1'b1);
    drive_cycle(mk(1, 5, 12, 1, 0), mk(1, 4, 11, 1, 0), ga, gb);
    chk("alt2_b", gb, 1'b1);
    drive_cycle(mk(1, 5, 12, 1, 0), mk(1, 1, 13, 1, 0), ga, gb);
    chk("alt3_a", ga, 1'b1);
    drive_cycle(none, mk(1, 1, 13, 1, 0), ga, gb);
    chk("alt4_b", gb, 1'b1);
    drain();

    ra = none; rb = none;
    for (int i = 0; i < 300; i++) begin
      if (!ra.v && $urandom_range(1, 0) == 1) new_req(ra, rb);
      if (!rb.v && $urandom_range(1, 0) == 1) new_req(rb, ra);
      drive_cycle(ra, rb, ga, gb);
      if (ga) ra.v = 0;
      if (gb) rb.v = 0;
    end
    drain();

    // Blink: digit 1 blinks, digit 0 steady; compare every cycle against the scan/phase timeline.
    do_reset();
    drive_cycle(mk(1, 0, 3, 0, 0), none, ga, gb);
    w0 = cyc - 1;
    drive_cycle(mk(1, 1, 7, 0, 1), none, ga, gb);
    w1 = cyc - 1;
    for (int i = 0; i < 48; i++) begin
      @(posedge clk); #2;
      chk("blink_d1", hex_out[13:7], exp_slice(1, cyc, w1, 7'b1011000, 1));
      chk("steady_d0", hex_out[6:0], exp_slice(0, cyc, w0, 7'b0110000, 0));
    end
    #1;
    drain();

    drive_cycle(mk(1, 1, 7, 0, 0), none, ga, gb);
    drain();

    snap = hex_out;
    chk("err_before", err, 1'b0);
    drive_cycle(mk(1, 6, 5, 0, 0), none, ga, gb);
    chk("oor_accepted", ga, 1'b1);
    idle(N + 3);
    chk("oor_hex_unchanged", hex_out, snap);
    chk("oor_err_set", err, 1'b1);
    idle(5);
    chk("oor_err_held", err, 1'b1);
    drain();

    // Reset mid-scan with a request present; then both valid on the first cycle out of reset.
    rst = 1;
    drive_cycle(mk(1, 0, 7, 0, 0), none, ga, gb);
    chk("rst_blocks_write", ga, 1'b0);
    chk("midrst_hex_out", hex_out, {N{SEG_BLANK}});
    chk("midrst_err", err, 1'b0);
    rst = 0;
    r_cyc = cyc;
    drive_cycle(mk(1, 4, 12, 1, 0), mk(1, 5, 13, 1, 0), ga, gb);
    chk("post_rst_a_first", ga, 1'b1);
    drive_cycle(none, mk(1, 5, 13, 1, 0), ga, gb);
    drain();
    for (int d = 0; d < 4; d++) chk($sformatf("post_rst_blank%0d", d), hex_out[d*7 +: 7], SEG_BLANK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
